sha_job_ctrl: RTL
=================

Name: sha_job_ctrl

Overview:
- Host-side job controller that drives the miner core: it is the initiator for the core's en/done handshake.
- It accepts a mining job as a 32-bit word stream and assembles the midstate, the header tail and the target.
- It pulses the core's start, holds the job stable until done, then streams a result frame back to the host.
- It sits between the host stream interface and the miner core.

Parameters:
- WORD_S, 32, stream word and nonce width.
- H_SIZE, 256, midstate/target/hash width (8 words).
- INPUT_S, 96, header tail width (3 words).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- s_data  in  WORD_S  job word.
- s_valid  in  1  job word valid.
- s_last  in  1  last word of job frame.
- s_ready  out  1  controller accepts a job word.
- m_data  out  WORD_S  result word.
- m_valid  out  1  result word valid.
- m_last  out  1  last result word.
- m_ready  in  1  host accepts a result word.
- miner_en  out  1  one-cycle start pulse to the core.
- prev_H  out  H_SIZE  midstate to the core.
- input_M  out  INPUT_S  header tail to the core.
- prev_blk  out  H_SIZE  target to the core.
- miner_done  in  1  core finished (one-cycle pulse).
- miner_found  in  1  valid with miner_done.
- miner_nonce  in  WORD_S  valid with miner_done.
- miner_H  in  H_SIZE  valid with miner_done and miner_found.
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (reset=0, async): state=LOAD, word counter=0, job_id=0.
  - All outputs 0, except s_ready=1 once reset deasserts.
  - prev_H, input_M and prev_blk are cleared to 0.
- Transfer rule: a word moves when valid&&ready on a rising clk edge.
- Job frame is exactly 19 words, first word is most significant:
  - words 0-7 go to prev_H[255:0], word 0 into bits 255:224;
  - words 8-10 go to input_M[95:0];
  - words 11-18 go to prev_blk[255:0].
- LOAD:
  - s_ready=1; each accepted word is shifted into place and the counter increments.
  - s_last on word 18 (counter==18): go to START.
  - s_last before word 18: set frame_err, go to SEND_ERR.
  - Word 18 without s_last: set frame_err, go to DISCARD.
- DISCARD: s_ready=1; drop words until an accepted word has s_last=1, then go to SEND_ERR.
- START: miner_en=1 for exactly one cycle; s_ready=0; go to WAIT.
- WAIT:
  - prev_H, input_M and prev_blk are held unchanged.
  - On miner_done, latch found, nonce and hash (hash latched only when found, else 0), then go to SEND.
  - miner_done is ignored in every other state.
  - No timeout: an exhaustive search returns with found=0.
- SEND: 10 words, m_valid=1 throughout, m_last on word 9.
  - Word 0 = {job_id[15:0], 14'b0, frame_err=0, found}.
  - Word 1 = nonce.
  - Words 2-9 = hash, MSW first.
  - m_data is held while m_valid&&!m_ready.
  - After word 9 is accepted: job_id+1 (wraps 0xFFFF->0), counter=0, go to LOAD.
- SEND_ERR: single word {job_id, 14'b0, 1'b1, 1'b0} with m_last=1.
  - After it is accepted: clear frame_err, go to LOAD. job_id is not incremented.
- Stream ordering:
  - s_ready and m_valid are never high together.
  - No new job is accepted until the result frame has fully drained.
- Reset mid-operation clears everything immediately.
  - The core's own reset is separate; the core may still pulse miner_done afterwards.
  - That pulse is ignored because the state is then LOAD.

Test Plan:
- Basic job: send 19 words (prev_H=0x00000001..0x00000008, input_M=0xA,0xB,0xC, prev_blk=0xFFFF…) with s_last on word 18.
  - One miner_en pulse.
  - Model core returns done with found=1, nonce=0x12345678, H=0x0000_00FF…
  - Result: status=0x00000001, word1=0x12345678, hash words in order, m_last on word 9.
- Not found: core returns found=0, nonce=0xFFFFFFFF.
  - Status=0x00000000, word1=0xFFFFFFFF, words 2-9 = 0.
  - Second job reports job_id=1 in status[31:16].
- Short frame: s_last on word 5.
  - No miner_en; single error word 0x00000002 with m_last.
  - A following good job works and has job_id=0.
- Long frame: 22 words, s_last on word 21.
  - Words 19-21 are dropped; error word 0x00000002 is sent.
- Backpressure: hold m_ready=0 for 7 cycles on word 3 and randomise s_valid gaps.
  - m_data stays stable while stalled, no words are lost or duplicated, s_ready stays 0 during SEND.
- Async reset asserted during WAIT, then core pulses miner_done.
  - Outputs are 0 immediately; no result frame follows; s_ready=1 after reset is released.

Source files
------------

// File: rtl/sha_job_ctrl.sv
// sha_job_ctrl
//   Host-side job controller for the miner core. It collects a 19-word job
//   frame from the host stream, pulses the core's start, and holds the job
//   stable while the core searches. When the core reports done, it returns a
//   10-word result frame. A malformed frame gets a single error word instead.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready   job word stream from the host
//   m_data/m_valid/m_last/m_ready   result word stream to the host
//   miner_en              one-cycle start pulse to the core
//   prev_H/input_M/prev_blk         midstate, header tail and target to the core
//   miner_done/found/nonce/H        completion report from the core
//   busy                  high whenever the controller is not in LOAD
//
// States
//   LOAD     | accepting job words into midstate / tail / target
//   DISCARD  | frame too long, dropping words up to s_last
//   START    | one-cycle miner_en pulse
//   WAIT     | job held stable, waiting for miner_done
//   SEND     | streaming status, nonce and 8 hash words
//   SEND_ERR | streaming the single frame-error word
module sha_job_ctrl #(
  parameter int WORD_S  = 32,
  parameter int H_SIZE  = 256,
  parameter int INPUT_S = 96
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_S-1:0]  s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [WORD_S-1:0]  m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic               miner_en,
  output logic [H_SIZE-1:0]  prev_H,
  output logic [INPUT_S-1:0] input_M,
  output logic [H_SIZE-1:0]  prev_blk,
  input  logic               miner_done,
  input  logic               miner_found,
  input  logic [WORD_S-1:0]  miner_nonce,
  input  logic [H_SIZE-1:0]  miner_H,
  output logic               busy
);

  localparam int NH = H_SIZE / WORD_S;
  localparam int NI = INPUT_S / WORD_S;
  localparam logic [4:0] CNT_H_END = 5'(NH);
  localparam logic [4:0] CNT_I_END = 5'(NH + NI);
  localparam logic [4:0] CNT_LAST  = 5'(2 * NH + NI - 1);
  localparam logic [3:0] IDX_LAST  = 4'(NH + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_DISCARD,
    S_START,
    S_WAIT,
    S_SEND,
    S_SEND_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [15:0]          job_id_q, job_id_d;
  logic                 frame_err_q, frame_err_d;
  logic                 found_q, found_d;
  logic [WORD_S-1:0]    nonce_q, nonce_d;
  logic [H_SIZE-1:0]    hash_q, hash_d;
  logic [H_SIZE-1:0]    prev_H_q, prev_H_d;
  logic [INPUT_S-1:0]   input_M_q, input_M_d;
  logic [H_SIZE-1:0]    prev_blk_q, prev_blk_d;

  logic s_ready_c;
  logic s_fire;
  logic m_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      job_id_q    <= '0;
      frame_err_q <= 1'b0;
      found_q     <= 1'b0;
      nonce_q     <= '0;
      hash_q      <= '0;
      prev_H_q    <= '0;
      input_M_q   <= '0;
      prev_blk_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      job_id_q    <= job_id_d;
      frame_err_q <= frame_err_d;
      found_q     <= found_d;
      nonce_q     <= nonce_d;
      hash_q      <= hash_d;
      prev_H_q    <= prev_H_d;
      input_M_q   <= input_M_d;
      prev_blk_q  <= prev_blk_d;
    end
  end

  // s_ready is gated by reset so it stays low while reset is asserted even
  // though the state register already sits in LOAD.
  assign s_ready = reset & s_ready_c;
  assign s_fire  = s_valid & s_ready_c;
  assign m_fire  = m_valid & m_ready;

  assign prev_H   = prev_H_q;
  assign input_M  = input_M_q;
  assign prev_blk = prev_blk_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    job_id_d    = job_id_q;
    frame_err_d = frame_err_q;
    found_d     = found_q;
    nonce_d     = nonce_q;
    hash_d      = hash_q;
    prev_H_d    = prev_H_q;
    input_M_d   = input_M_q;
    prev_blk_d  = prev_blk_q;
    s_ready_c   = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = '0;
    miner_en    = 1'b0;
    busy        = 1'b1;

    case (state_q)
      S_LOAD: begin
        busy      = 1'b0;
        s_ready_c = 1'b1;
        if (s_fire) begin
          // Words are shifted in from the bottom so the first word of each
          // field ends up in its most significant position.
          if (cnt_q < CNT_H_END) begin
            prev_H_d = {prev_H_q[H_SIZE-WORD_S-1:0], s_data};
          end else if (cnt_q < CNT_I_END) begin
            input_M_d = {input_M_q[INPUT_S-WORD_S-1:0], s_data};
          end else begin
            prev_blk_d = {prev_blk_q[H_SIZE-WORD_S-1:0], s_data};
          end
          if (s_last) begin
            cnt_d = '0;
            if (cnt_q == CNT_LAST) begin
              state_d = S_START;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_SEND_ERR;
            end
          end else if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            frame_err_d = 1'b1;
            state_d     = S_DISCARD;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_DISCARD: begin
        s_ready_c = 1'b1;
        if (s_fire && s_last) begin
          state_d = S_SEND_ERR;
        end
      end

      S_START: begin
        miner_en = 1'b1;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (miner_done) begin
          found_d = miner_found;
          nonce_d = miner_nonce;
          hash_d  = miner_found ? miner_H : '0;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        m_valid = 1'b1;
        m_last  = (idx_q == IDX_LAST);
        if (idx_q == 4'd0) begin
          m_data = {job_id_q, {(WORD_S-18){1'b0}}, 1'b0, found_q};
        end else if (idx_q == 4'd1) begin
          m_data = nonce_q;
        end else begin
          m_data = hash_q[H_SIZE-1 -: WORD_S];
        end
        if (m_fire) begin
          // The hash register is consumed MSW first by shifting it up.
          if (idx_q >= 4'd2) begin
            hash_d = {hash_q[H_SIZE-WORD_S-1:0], {WORD_S{1'b0}}};
          end
          if (idx_q == IDX_LAST) begin
            job_id_d = job_id_q + 16'd1;
            cnt_d    = '0;
            idx_d    = '0;
            state_d  = S_LOAD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      S_SEND_ERR: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_data  = {job_id_q, {(WORD_S-18){1'b0}}, 1'b1, 1'b0};
        if (m_fire) begin
          frame_err_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_LOAD;
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

endmodule
